// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: drains an upstream FIFO into a 2-entry valid/ready buffer.
// Define FIFO_RD_CTRL_TIMEOUT_EN to flush short bursts after cfg_timeout idle cycles.
module fifo_rd_ctrl #(
  parameter int data_width  = 32,
  parameter int depth_width = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  fifo_rd,
  input  logic [data_width-1:0] fifo_rd_data,
  input  logic                  fifo_rd_data_vld,
  input  logic [depth_width:0]  fifo_num,
  input  logic [depth_width:0]  cfg_burst_len,
  input  logic [7:0]            cfg_timeout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int CW = depth_width + 1;
  localparam logic [CW-1:0] MAXLEN = {1'b1, {depth_width{1'b0}}};
  localparam logic [CW-1:0] ONE = {{depth_width{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         blen_q, blen_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q;
  logic                  last_fl_q;
  logic                  m_valid_q, m_valid_d;
  logic [data_width-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic [data_width-1:0] b1_data_q, b1_data_d;
  logic                  b1_last_q, b1_last_d;

  logic                  xfer;
  logic                  cap;
  logic                  rd;
  logic                  rd_last;
  logic [2:0]            occ;
  logic [CW-1:0]         blen_cfg;
  logic                  tmo_hit;

  assign xfer = m_valid_q & m_ready;
  assign cap  = fifo_rd_data_vld;
  assign occ  = {1'b0, cnt_q} + {2'b00, inflight_q};

  always_comb begin
    blen_cfg = cfg_burst_len;
    if (cfg_burst_len == '0) begin
      blen_cfg = ONE;
    end else if (cfg_burst_len > MAXLEN) begin
      blen_cfg = MAXLEN;
    end
  end

  // a read may be issued into a full pipe only if a slot frees this cycle
  assign rd = (state_q == BURST)
            && (issued_q < blen_q)
            && (fifo_num != '0)
            && ((occ < 3'd2) || ((occ == 3'd2) && xfer));
  assign rd_last = rd && ((issued_q + ONE) == blen_q);

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       tmo_arm;

  assign tmo_arm = (state_q == IDLE)
                && (fifo_num != '0)
                && (fifo_num < blen_cfg);
  assign tmo_hit = tmo_arm
                && (cfg_timeout != 8'd0)
                && ((tmo_q + 8'd1) == cfg_timeout);
  assign tmo_d = (tmo_arm && !tmo_hit) ? tmo_q + 8'd1 : 8'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic unused_tmo;

  assign unused_tmo = ^cfg_timeout;
  assign tmo_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    blen_d   = blen_q;
    issued_d = issued_q;
    unique case (state_q)
      IDLE: begin
        if (fifo_num >= blen_cfg) begin
          state_d  = BURST;
          blen_d   = blen_cfg;
          issued_d = '0;
        end else if (tmo_hit) begin
          state_d  = BURST;
          blen_d   = fifo_num;
          issued_d = '0;
        end
      end
      BURST: begin
        if (rd) begin
          issued_d = issued_q + ONE;
        end
        if (issued_d == blen_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && m_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    b1_data_d = b1_data_q;
    b1_last_d = b1_last_q;
    unique case (cnt_q)
      2'd0: begin
        if (cap) begin
          m_data_d = fifo_rd_data;
          m_last_d = last_fl_q;
          cnt_d    = 2'd1;
        end
      end
      2'd1: begin
        if (cap && xfer) begin
          m_data_d = fifo_rd_data;
          m_last_d = last_fl_q;
        end else if (xfer) begin
          cnt_d = 2'd0;
        end else if (cap) begin
          b1_data_d = fifo_rd_data;
          b1_last_d = last_fl_q;
          cnt_d     = 2'd2;
        end
      end
      2'd2: begin
        if (xfer) begin
          m_data_d = b1_data_q;
          m_last_d = b1_last_q;
          if (cap) begin
            b1_data_d = fifo_rd_data;
            b1_last_d = last_fl_q;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
    m_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      blen_q     <= ONE;
      issued_q   <= '0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
      last_fl_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      b1_data_q  <= '0;
      b1_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      blen_q     <= blen_d;
      issued_q   <= issued_d;
      cnt_q      <= cnt_d;
      inflight_q <= rd;
      last_fl_q  <= rd_last;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      b1_data_q  <= b1_data_d;
      b1_last_q  <= b1_last_d;
    end
  end

  assign fifo_rd = rd;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model, in-order scoreboard, vector table,
// directed corner sequences and randomized traffic.
module tb_fifo_rd_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          fifo_rd;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_data_vld = 1'b0;
  logic [AW:0]   fifo_num = '0;
  logic [AW:0]   cfg_burst_len = 6'd4;
  logic [7:0]    cfg_timeout = 8'd0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] next_w = 32'hA500_0000;
  logic [DW-1:0] pw;
  logic [DW-1:0] ew;
  logic [DW-1:0] hd;
  logic          hl;
  logic          hold = 1'b0;
  logic          rd_s = 1'b0;
  int push_n = 0;
  int pushed = 0;
  int xfers = 0;
  int lasts = 0;
  int model_blen = 1;
  int widx = 0;

  typedef struct {
    logic [AW:0] cfg;
    int          len;
  } vec_t;

  vec_t tbl[7];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(
    .data_width (DW),
    .depth_width(AW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .fifo_rd         (fifo_rd),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_rd_data_vld(fifo_rd_data_vld),
    .fifo_num        (fifo_num),
    .cfg_burst_len   (cfg_burst_len),
    .cfg_timeout     (cfg_timeout),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_last          (m_last),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) rd_s <= fifo_rd;

  // upstream FIFO: occupancy drops on the read edge, data one cycle later
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fq.delete();
      exp_q.delete();
      fifo_rd_data_vld <= 1'b0;
      fifo_rd_data     <= '0;
      fifo_num         <= '0;
    end else begin
      if (rd_s) begin
        chk("rd_nonempty", fq.size() != 0, 1);
        if (fq.size() != 0) begin
          pw = fq.pop_front();
          exp_q.push_back(pw);
          fifo_rd_data <= pw;
        end
      end
      fifo_rd_data_vld <= rd_s;
      for (int i = 0; i < push_n; i++) begin
        if (fq.size() < 32) begin
          fq.push_back(next_w);
          next_w = next_w + 32'h1357;
          pushed++;
        end
      end
      fifo_num <= (AW+1)'(fq.size());
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      widx = 0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, hd);
        chk("hold_last", m_last, hl);
      end
      if (m_valid && m_ready) begin
        chk("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ew = exp_q.pop_front();
          chk("xfer_data", m_data, ew);
        end
        chk("xfer_last", m_last, (widx + 1) == model_blen);
        widx = ((widx + 1) == model_blen) ? 0 : widx + 1;
        xfers++;
        if (m_last) lasts++;
      end
      hold = m_valid && !m_ready;
      hd   = m_data;
      hl   = m_last;
    end
  end

  task automatic load(input int n);
    @(posedge clk); #1 push_n = n;
    @(posedge clk); #1 push_n = 0;
  endtask

  task automatic wait_lasts(input string name, input int target);
    int t = 0;
    while (lasts < target && t < 400) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk(name, lasts >= target, 1);
  endtask

  task automatic run_vec(input logic [AW:0] cfg, input int len);
    int t = 0;
    int first_rd = -1;
    int last_rd = -1;
    int nrd = 0;
    int first_v = -1;
    int x0;
    int l0;
    bit done = 0;
    cfg_burst_len = cfg;
    model_blen = len;
    m_ready = 1'b1;
    x0 = xfers;
    l0 = lasts;
    load(len);
    while (!done && t < 300) begin
      @(negedge clk);
      if (fifo_rd) begin
        if (first_rd < 0) first_rd = t;
        last_rd = t;
        nrd++;
      end
      if (m_valid && first_v < 0) first_v = t;
      if (m_valid && m_last) done = 1;
      t++;
    end
    @(negedge clk);
    chk("vec_done", done, 1);
    chk("vec_rd_count", nrd, len);
    chk("vec_rd_consec", last_rd - first_rd, len - 1);
    chk("vec_first_valid", first_v - first_rd, 2);
    chk("vec_xfers", xfers - x0, len);
    chk("vec_lasts", lasts - l0, 1);
    chk("vec_busy_after", busy, 0);
  endtask

  initial begin
    int x0;
    int l0;
    int n;
    int t;
    int c;
    int avail;
    int p0;
    int total;

    tbl[0] = '{6'd0, 1};
    tbl[1] = '{6'd1, 1};
    tbl[2] = '{6'd4, 4};
    tbl[3] = '{6'd7, 7};
    tbl[4] = '{6'd32, 32};
    tbl[5] = '{6'd33, 32};
    tbl[6] = '{6'd63, 32};

    #1;
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", m_valid, 0);

    for (int i = 0; i < 7; i++) begin
      run_vec(tbl[i].cfg, tbl[i].len);
    end

`ifdef FIFO_RD_CTRL_TIMEOUT_EN
    cfg_burst_len = 6'd4;
    cfg_timeout = 8'd10;
    model_blen = 3;
    x0 = xfers;
    l0 = lasts;
    load(3);
    n = -1;
    t = 0;
    while (n < 0 && t < 100) begin
      @(negedge clk);
      if (fifo_rd) n = t;
      t++;
    end
    chk("tmo_start", n, 10);
    wait_lasts("tmo_last", l0 + 1);
    chk("tmo_xfers", xfers - x0, 3);
    @(posedge clk); #1 cfg_timeout = 8'd0;
`endif

    cfg_burst_len = 6'd4;
    model_blen = 4;
    x0 = xfers;
    l0 = lasts;
    load(3);
    n = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fifo_rd) n++;
    end
    chk("short_no_rd", n, 0);
    chk("short_idle", busy, 0);
    load(1);
    wait_lasts("short_topup_last", l0 + 1);
    chk("short_topup_xfers", xfers - x0, 4);

    cfg_burst_len = 6'd8;
    model_blen = 8;
    x0 = xfers;
    l0 = lasts;
    load(8);
    t = 0;
    while (!busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1 cfg_burst_len = 6'd2;
    wait_lasts("midcfg_last", l0 + 1);
    chk("midcfg_xfers", xfers - x0, 8);

    cfg_burst_len = 6'd8;
    model_blen = 8;
    x0 = xfers;
    l0 = lasts;
    load(8);
    t = 0;
    while (lasts < l0 + 1 && t < 200) begin
      @(posedge clk); #1 m_ready = ~m_ready;
      t++;
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    chk("toggle_last", lasts - l0, 1);
    chk("toggle_xfers", xfers - x0, 8);

    cfg_burst_len = 6'd6;
    model_blen = 6;
    x0 = xfers;
    load(6);
    t = 0;
    while (xfers < x0 + 2 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    rstn = 1'b0;
    #1;
    chk("rstmid_fifo_rd", fifo_rd, 0);
    chk("rstmid_m_valid", m_valid, 0);
    chk("rstmid_m_data", m_data, 0);
    chk("rstmid_m_last", m_last, 0);
    chk("rstmid_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid || busy || fifo_rd) n++;
    end
    chk("rstmid_quiet", n, 0);
    x0 = xfers;
    l0 = lasts;
    load(6);
    wait_lasts("rstmid_new_last", l0 + 1);
    chk("rstmid_new_xfers", xfers - x0, 6);

    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #1;
      c = $urandom_range(1, 8);
      cfg_burst_len = (AW+1)'(c);
      model_blen = c;
      avail = int'(fifo_num);
      p0 = pushed;
      x0 = xfers;
      repeat (1500) begin
        @(posedge clk); #1;
        push_n = ($urandom_range(0, 2) == 0) ? 1 : 0;
        m_ready = ($urandom_range(0, 3) != 0);
      end
      push_n = 0;
      m_ready = 1'b1;
      repeat (200) @(posedge clk);
      @(negedge clk);
      total = avail + (pushed - p0);
      chk("rand_xfers", xfers - x0, total - (total % c));
      chk("rand_left", fifo_num, total % c);
      chk("rand_sb_empty", exp_q.size(), 0);
      chk("rand_idle", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
